// File: rtl/fxp_to_fp16_if.sv
// rtl/fxp_to_fp16_if.sv - handshake bundle between the MAC accumulator and the FP16 normaliser
// Purpose: groups the input (accumulator/exponent) and output (FP16/flags) handshakes.
// Ports:   in_valid/in_ready/acc_in/exp_in   - accumulator side
//          out_valid/out_ready/fp_out/overflow/underflow - result side
//          slave modport = normaliser, master modport = producer/consumer
`timescale 1ns/1ps
interface fxp_to_fp16_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ACC_WIDTH-1:0] acc_in;
    logic [4:0]           exp_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          fp_out;
    logic                 overflow;
    logic                 underflow;

    modport slave (
        input  in_valid, acc_in, exp_in, out_ready,
        output in_ready, out_valid, fp_out, overflow, underflow
    );

    modport master (
        output in_valid, acc_in, exp_in, out_ready,
        input  in_ready, out_valid, fp_out, overflow, underflow
    );
endinterface

// File: rtl/fxp_to_fp16.sv
// rtl/fxp_to_fp16.sv - signed fixed-point accumulator to IEEE-754 half precision
// Purpose: converts acc_in * 2^(exp_in - EXP_BIAS - FRAC_BITS) to FP16 with
//          round-to-nearest-even, saturation to inf and flush-to-zero, through
//          an IDLE -> NORM -> ROUND -> HOLD FSM.
// Ports:   clk - rising-edge clock
//          rst - asynchronous active-low reset
//          bus - fxp_to_fp16_if.slave (input and output handshakes, result flags)
`timescale 1ns/1ps
module fxp_to_fp16 #(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int EXP_BIAS  = 15
) (
    input logic           clk,
    input logic           rst,
    fxp_to_fp16_if.slave  bus
);
    // Magnitude is one bit wider than the accumulator so the most negative value is exact.
    localparam int W  = ACC_WIDTH + 1;
    localparam int MW = 10;
    localparam int SW = $clog2(W + 1) + 1;
    localparam logic [W-1:0] W_ONE = W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [4:0]           r_exp;
    logic                 r_sign;
    logic                 r_zero;
    logic signed [7:0]    r_e;
    logic [MW-1:0]        r_m;
    logic                 r_g;
    logic                 r_s;
    logic [15:0]          r_fp;
    logic                 r_ovf;
    logic                 r_unf;

    // Normalisation of the captured accumulator
    logic [W-1:0]         w_mag;
    logic [W-1:0]         w_aligned;
    logic [SW-1:0]        w_p;
    logic signed [7:0]    w_e;
    logic [MW-1:0]        w_m;
    logic                 w_g;
    logic                 w_s;

    always_comb begin
        w_mag = r_acc[ACC_WIDTH-1] ? (~{r_acc[ACC_WIDTH-1], r_acc} + W_ONE)
                                   : {1'b0, r_acc};
        w_p = '0;
        for (int i = 0; i < W; i++) begin
            if (w_mag[i]) w_p = SW'(i);
        end
        // Shifting by W-p pushes the implicit leading one off the top, leaving
        // the fraction bits left-aligned (zero-padded when p is small).
        w_aligned = w_mag << (SW'(W) - w_p);
        // exp_in and the FP16 field share the same bias: unbias, then rebias.
        w_e = 8'(int'(w_p) + int'(r_exp) - EXP_BIAS - FRAC_BITS + EXP_BIAS);
        w_m = w_aligned[W-1 -: MW];
        w_g = w_aligned[W-1-MW];
        w_s = |w_aligned[W-2-MW:0];
    end

    // Rounding and range classification of the normalised value
    logic                 w_up;
    logic [MW:0]          w_mr;
    logic signed [8:0]    w_er;
    logic [15:0]          w_fp;
    logic                 w_ovf;
    logic                 w_unf;

    always_comb begin
        w_up  = r_g & (r_s | r_m[0]);
        w_mr  = {1'b0, r_m} + {{MW{1'b0}}, w_up};
        // Mantissa carry-out bumps the exponent; the low MW bits are already zero.
        w_er  = {r_e[7], r_e} + {8'b0, w_mr[MW]};
        w_fp  = {r_sign, w_er[4:0], w_mr[MW-1:0]};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_zero) begin
            w_fp = 16'h0000;
        end else if (w_er >= 9'sd31) begin
            w_fp  = {r_sign, 5'h1F, 10'h000};
            w_ovf = 1'b1;
        end else if (w_er <= 9'sd0) begin
            w_fp  = {r_sign, 15'h0000};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_zero  <= 1'b0;
            r_e     <= '0;
            r_m     <= '0;
            r_g     <= 1'b0;
            r_s     <= 1'b0;
            r_fp    <= 16'h0000;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_acc   <= bus.acc_in;
                        r_exp   <= bus.exp_in;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_sign  <= r_acc[ACC_WIDTH-1];
                    r_zero  <= (w_mag == '0);
                    r_e     <= w_e;
                    r_m     <= w_m;
                    r_g     <= w_g;
                    r_s     <= w_s;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_fp    <= w_fp;
                    r_ovf   <= w_ovf;
                    r_unf   <= w_unf;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.fp_out    = r_fp;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
endmodule

// File: tb/tb_fxp_to_fp16.sv
// tb/tb_fxp_to_fp16.sv - directed-vector self-checking bench for fxp_to_fp16
`timescale 1ns/1ps
module tb_fxp_to_fp16;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fxp_to_fp16_if #(.ACC_WIDTH(32)) bus ();

    fxp_to_fp16 #(
        .ACC_WIDTH(32),
        .FRAC_BITS(10),
        .EXP_BIAS (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one input, verify accept/latency/result, complete the handshake with out_ready=1.
    task automatic convert(input string tag, input logic [31:0] acc, input logic [4:0] ex,
                           input logic [15:0] exp_fp, input logic exp_ovf, input logic exp_unf);
        int t;
        bus.acc_in   = acc;
        bus.exp_in   = ex;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, bus.in_ready, 0);
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_latency"}, t, 2);
        check({tag, "_fp"}, bus.fp_out, exp_fp);
        check({tag, "_ovf"}, bus.overflow, exp_ovf);
        check({tag, "_unf"}, bus.underflow, exp_unf);
        @(posedge clk); #1;
        check({tag, "_ov_drop"}, bus.out_valid, 0);
        check({tag, "_rdy_back"}, bus.in_ready, 1);
    endtask

    initial begin
        int t;
        n_checks = 0;
        n_errors = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.acc_in   = '0;
        bus.exp_in   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_fp", bus.fp_out, 16'h0000);
        check("rst_flags", {bus.overflow, bus.underflow}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        convert("basic",     32'd8310,        5'd16, 16'h4C0F, 1'b0, 1'b0);
        convert("neg",       -32'sd8310,      5'd16, 16'hCC0F, 1'b0, 1'b0);
        convert("zero",      32'd0,           5'd7,  16'h0000, 1'b0, 1'b0);
        convert("tie_even",  32'd2049,        5'd15, 16'h4000, 1'b0, 1'b0);
        convert("tie_up",    32'd2051,        5'd15, 16'h4002, 1'b0, 1'b0);
        convert("carry",     32'd4095,        5'd15, 16'h4400, 1'b0, 1'b0);
        convert("ovf_pos",   32'h7FFFFFFF,    5'd31, 16'h7C00, 1'b1, 1'b0);
        convert("ovf_neg",   32'h80000000,    5'd31, 16'hFC00, 1'b1, 1'b0);
        convert("unf_pos",   32'd1,           5'd0,  16'h0000, 1'b0, 1'b1);
        convert("unf_neg",   32'hFFFFFFFF,    5'd0,  16'h8000, 1'b0, 1'b1);
        convert("max_norm",  32'd1024,        5'd30, 16'h7800, 1'b0, 1'b0);
        convert("min_norm",  32'd1024,        5'd1,  16'h0400, 1'b0, 1'b0);
        convert("e_zero",    32'd1024,        5'd0,  16'h0000, 1'b0, 1'b1);
        convert("carry_ovf", 32'd4095,        5'd29, 16'h7C00, 1'b1, 1'b0);

        // Back-pressure: result must hold, busy input ignored.
        bus.out_ready = 1'b0;
        bus.acc_in    = 32'd2049;
        bus.exp_in    = 5'd15;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("bp_latency", t, 2);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.acc_in   = 32'd4095;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check($sformatf("bp_fp_%0d", i), bus.fp_out, 16'h4000);
            check($sformatf("bp_rdy_%0d", i), {bus.in_ready, bus.out_valid}, 2'b01);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", bus.out_valid, 0);
        check("bp_release_rdy", bus.in_ready, 1);
        convert("bp_next",   32'd2051,        5'd15, 16'h4002, 1'b0, 1'b0);

        // Reset mid-operation; previous result 0x4002 is still on fp_out.
        bus.acc_in   = -32'sd8310;
        bus.exp_in   = 5'd16;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_ov", bus.out_valid, 0);
        check("mid_rst_fp", bus.fp_out, 16'h0000);
        check("mid_rst_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        check("mid_rst_hold", {bus.out_valid, bus.fp_out}, 17'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        convert("after_rst", 32'd8310,        5'd16, 16'h4C0F, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fxp_to_fp16.md
# fxp_to_fp16

Output normaliser for the FP16×INT4 MAC datapath. It consumes the accumulator word and block exponent (`exp_min`) that the MAC produces and converts them back into an IEEE-754 half-precision value. Rounding is round-to-nearest-even, overflow saturates to infinity, and underflow flushes to zero. It sits directly downstream of `fp_int_mac` and runs as a small multi-cycle FSM with valid/ready handshakes on both sides.

## Interface
- `ACC_WIDTH`, default 32: accumulator width, two's complement.
- `FRAC_BITS`, default 10: fraction bits of the accumulator relative to the block exponent. This is the FP16 mantissa width.
- `EXP_BIAS`, default 15: FP16 exponent bias.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `acc_in` and `exp_in` are valid.
- `in_ready` output 1: block can accept a new input.
- `acc_in` input `ACC_WIDTH`: signed fixed-point accumulator. It is the MAC `fixed_point_out`.
- `exp_in` input 5: block exponent. It is the MAC `exp_out`/`exp_min`.
- `out_valid` output 1: `fp_out` and the flags are valid.
- `out_ready` input 1: downstream accepts the result.
- `fp_out` output 16: FP16 result.
- `overflow` output 1: the result saturated to ±inf.
- `underflow` output 1: a nonzero input was flushed to ±0.

## Operation
- **Value definition:** real = `acc_in` × 2^(`exp_in` − `EXP_BIAS` − `FRAC_BITS`).
- **States:** IDLE, NORM, ROUND, HOLD.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`, capture `acc_in`/`exp_in` and go to NORM.
- **NORM:**
  - sign = `acc_in`[MSB].
  - mag = |`acc_in`|, computed `ACC_WIDTH`+1 bits wide so that −2^31 is exact.
  - p = index of the leading one of mag.
  - Biased exponent E = p + `exp_in` − `FRAC_BITS`, held as a signed 8-bit value.
  - Left-align mag so the leading one is dropped. Take m = the next 10 bits, g = the guard bit after them, s = the OR of all remaining bits.
  - If p<10, m is zero-padded and g=s=0.
  - Register all of these, then go to ROUND.
- **ROUND:**
  - Round up if g && (s || m[0]).
  - If the mantissa carries out, m=0 and E=E+1.
  - Zero: if mag==0, `fp_out`=0x0000 (always positive zero) and both flags are 0.
  - Overflow: if E≥31, `fp_out`={sign,5'h1F,10'h0} and `overflow`=1.
  - Underflow: if E≤0 and mag≠0, `fp_out`={sign,15'h0} and `underflow`=1. Subnormals are not produced.
  - Otherwise `fp_out`={sign,E[4:0],m}.
  - Register the result and go to HOLD.
- **HOLD:**
  - `out_valid`=1. `fp_out` and the flags are held stable.
  - When `out_ready`=1, go to IDLE.
- **Interlock:** `in_ready`=0 in NORM, ROUND and HOLD. New inputs are never accepted while a result is pending.
- **Flag exclusivity:** `overflow` and `underflow` are never both 1.

## Timing
- **Reset values:** `out_valid`=0, `fp_out`=0x0000, `overflow`=0, `underflow`=0, state=IDLE.
- **`in_ready` source:** it is decoded from state, so it reads 1 during and after reset.
- **Latency:** accept at edge k → NORM after k, ROUND after k+1, and `out_valid`=1 after edge k+2.
- **Throughput:**
  - With `out_ready` tied high, HOLD lasts 1 cycle, so one conversion completes every 4 cycles.
  - `in_ready` returns to 1 the cycle after the output handshake.
- **Back-pressure:** while `out_valid`=1 and `out_ready`=0, the block holds HOLD indefinitely and outputs do not change.
- **Output handshake:** completes on the edge where `out_valid`&&`out_ready`. `out_valid` is 0 the following cycle.
- **Input while busy:** `in_valid` asserted outside IDLE is ignored. The source must hold it until `in_ready`.
- **Reset mid-operation:** asserting `rst` low at any point returns to IDLE immediately, clears `out_valid`/`fp_out`/flags and discards the conversion in flight.
- **Combinational paths:** none from inputs to outputs. `in_ready` and `out_valid` are decoded from state only.

## Test plan
- **Basic convert:** reset, then `acc_in`=8310, `exp_in`=16, `out_ready`=1. Require `fp_out`=0x4C0F, flags 0, `out_valid` on the 3rd cycle after accept, and `in_ready` back to 1 one cycle later.
- **Sign and zero:**
  - `acc_in`=−8310, `exp_in`=16 → 0xCC0F.
  - `acc_in`=0, any `exp_in` → 0x0000, flags 0.
- **Round-to-nearest-even, `exp_in`=15:**
  - `acc_in`=2049 → 0x4000 (tie, stays even).
  - `acc_in`=2051 → 0x4002 (tie, rounds up).
  - `acc_in`=4095 → mantissa carry, 0x4400.
- **Saturation and flush:**
  - `acc_in`=0x7FFFFFFF, `exp_in`=31 → 0x7C00, `overflow`=1.
  - `acc_in`=0x80000000, `exp_in`=31 → 0xFC00, `overflow`=1.
  - `acc_in`=1, `exp_in`=0 → 0x0000, `underflow`=1.
- **Back-pressure:**
  - Hold `out_ready`=0 for 10 cycles after `out_valid`. `fp_out` must stay stable and `in_ready` must stay 0.
  - Pulse `in_valid` with new data during the stall. It must be ignored.
  - Release `out_ready`. One handshake, then the next accept.
- **Reset mid-operation:** drive `rst` low one cycle after accept. Next cycle `out_valid`=0, `fp_out`=0 and state IDLE. A subsequent conversion (8310/16) must give 0x4C0F.
